// File: rtl/lvt_burst_master.sv
// Burst master for a 2-write / 8-read LVT memory: word-pair write bursts
// and 8-lane read bursts with a valid/ready beat output.
module lvt_burst_master #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2*DATA_W-1:0]   wr_data,
  output logic                  mem_w_en_1,
  output logic                  mem_w_en_2,
  output logic [ADDR_W-1:0]     mem_waddr_1,
  output logic [ADDR_W-1:0]     mem_waddr_2,
  output logic [DATA_W-1:0]     mem_wdin_1,
  output logic [DATA_W-1:0]     mem_wdin_2,
  output logic [8*ADDR_W-1:0]   mem_raddr,
  input  logic [8*DATA_W-1:0]   mem_rdata,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [8*DATA_W-1:0]   rd_data,
  output logic [7:0]            rd_mask,
  output logic                  rd_last,
  output logic                  done
);

  localparam int LANES = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cur;
  logic [8:0]          remaining;
  logic [LANES-1:0]    lane_mask;

  logic [8:0]          wr_take;
  logic [8:0]          rd_take;
  logic [LANES-1:0]    issue_mask;
  logic [8*ADDR_W-1:0] issue_raddr;
  logic                rd_slot_free;

  assign wr_take      = (remaining >= 9'd2) ? 9'd2 : remaining;
  assign rd_take      = (remaining >= 9'd8) ? 9'd8 : remaining;
  assign rd_slot_free = !rd_valid || rd_ready;

  // NOTE: every always_comb output gets a default before any conditional
  // update, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    issue_mask  = '0;
    issue_raddr = '0;
    for (int i = 0; i < LANES; i++) begin
      issue_mask[i]                  = (9'(i) < remaining);
      issue_raddr[i*ADDR_W +: ADDR_W] = cur + ADDR_W'(i);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cur         <= '0;
      remaining   <= '0;
      lane_mask   <= '0;
      cmd_ready   <= 1'b1;
      wr_ready    <= 1'b0;
      mem_w_en_1  <= 1'b0;
      mem_w_en_2  <= 1'b0;
      mem_waddr_1 <= '0;
      mem_waddr_2 <= '0;
      mem_wdin_1  <= '0;
      mem_wdin_2  <= '0;
      mem_raddr   <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_mask     <= '0;
      rd_last     <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_w_en_1 <= 1'b0;
      mem_w_en_2 <= 1'b0;
      done       <= 1'b0;

      // Consumer takes the pending beat; a capture below may replace it.
      if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        if (rd_last) done <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cur       <= cmd_addr;
            remaining <= {1'b0, cmd_len} + 9'd1;
            cmd_ready <= 1'b0;
            wr_ready  <= cmd_write;
            state     <= cmd_write ? WRITE : RD_ISSUE;
          end
        end

        WRITE: begin
          if (wr_valid && wr_ready) begin
            mem_w_en_1  <= 1'b1;
            mem_waddr_1 <= cur;
            mem_wdin_1  <= wr_data[DATA_W-1:0];
            mem_w_en_2  <= (remaining >= 9'd2);
            mem_waddr_2 <= cur + ADDR_W'(1);
            mem_wdin_2  <= wr_data[2*DATA_W-1:DATA_W];
            cur         <= cur + ADDR_W'(2);
            remaining   <= remaining - wr_take;
            if (remaining <= 9'd2) begin
              wr_ready  <= 1'b0;
              cmd_ready <= 1'b1;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        RD_ISSUE: begin
          // Issue only once the output slot is empty or being emptied.
          if (rd_slot_free) begin
            mem_raddr <= issue_raddr;
            lane_mask <= issue_mask;
            cur       <= cur + ADDR_W'(LANES);
            remaining <= remaining - rd_take;
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          rd_data   <= mem_rdata;
          rd_mask   <= lane_mask;
          rd_last   <= (remaining == 9'd0);
          rd_valid  <= 1'b1;
          cmd_ready <= (remaining == 9'd0);
          state     <= (remaining != 9'd0) ? RD_ISSUE : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // cur and cur+1 always differ, so the two write ports never collide.
  a_no_dual_conflict: assert property (@(posedge clk) disable iff (!rst)
    (mem_w_en_1 && mem_w_en_2) |-> (mem_waddr_1 != mem_waddr_2));

  a_ready_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(cmd_ready && wr_ready));

endmodule
